// File: rtl/cpu_axi_pkg.sv
// Shared constants and FSM state types for the CPU-to-AXI bridge.
// Imported by the bridge top and its arbiter.
package cpu_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic {
        R_IDLE,
        R_ADDR
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_SEND,
        W_RESP
    } wr_state_t;

endpackage

// File: rtl/cpu_axi_arb.sv
// Fixed-priority one-hot arbiter: lowest set request bit wins.
// Ports: req[N] in, grant[N] out (one-hot or zero), purely combinational.
module cpu_axi_arb #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    // Two's-complement trick isolates the lowest set bit.
    assign grant = req & (~req + N'(1));

endmodule

// File: rtl/cpu_axi_bridge.sv
// Bridges NUM_MST core req/ack ports onto one AXI master (single beats).
// Ports: clk, resetn, per-port req/wr/size/addr/wstrb/wdata -> addr_ok/data_ok/rdata;
// AXI AR/R/AW/W/B. Name clashes: axi_rdata in, axi_wdata/axi_wstrb out.
module cpu_axi_bridge
    import cpu_axi_pkg::*;
#(
    parameter int NUM_MST = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_MST-1:0]        req,
    input  logic [NUM_MST-1:0]        wr,
    input  logic [2*NUM_MST-1:0]      size,
    input  logic [ADDR_W*NUM_MST-1:0] addr,
    input  logic [4*NUM_MST-1:0]      wstrb,
    input  logic [DATA_W*NUM_MST-1:0] wdata,
    output logic [NUM_MST-1:0]        addr_ok,
    output logic [NUM_MST-1:0]        data_ok,
    output logic [DATA_W-1:0]         rdata,
    output logic [ID_W-1:0]           arid,
    output logic [ADDR_W-1:0]         araddr,
    output logic [7:0]                arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [ID_W-1:0]           rid,
    input  logic [DATA_W-1:0]         axi_rdata,
    input  logic [1:0]                rresp,
    input  logic                      rlast,
    input  logic                      rvalid,
    output logic                      rready,
    output logic [ID_W-1:0]           awid,
    output logic [ADDR_W-1:0]         awaddr,
    output logic [7:0]                awlen,
    output logic [2:0]                awsize,
    output logic [1:0]                awburst,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [DATA_W-1:0]         axi_wdata,
    output logic [3:0]                axi_wstrb,
    output logic                      wlast,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [ID_W-1:0]           bid,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready
);

    rd_state_t r_state, r_next;
    wr_state_t w_state, w_next;

    logic [NUM_MST-1:0] grant, rd_pend, r_ok, w_ok;
    logic [ADDR_W-1:0]  sel_addr, ar_addr, aw_addr;
    logic [1:0]         sel_size, ar_size, aw_size;
    logic [3:0]         sel_strb, w_strb;
    logic [DATA_W-1:0]  sel_data, w_data;
    logic [ID_W-1:0]    sel_id, ar_id, wr_owner;
    logic sel_wr, sel_pend, hazard;
    logic rd_go, wr_go;
    logic aw_done, w_done;
    logic unused_ok;

    cpu_axi_arb #(.N(NUM_MST)) u_arb (
        .req   (req),
        .grant (grant)
    );

    always_comb begin
        sel_addr = '0;
        sel_size = '0;
        sel_strb = '0;
        sel_data = '0;
        sel_id   = '0;
        sel_wr   = 1'b0;
        for (int k = 0; k < NUM_MST; k++) begin
            if (grant[k]) begin
                sel_addr = addr[k*ADDR_W +: ADDR_W];
                sel_size = size[k*2 +: 2];
                sel_strb = wstrb[k*4 +: 4];
                sel_data = wdata[k*DATA_W +: DATA_W];
                sel_id   = ID_W'(k);
                sel_wr   = wr[k];
            end
        end
    end

    // A read may not overtake a pending write to the same word.
    assign sel_pend = |(grant & rd_pend);
    assign hazard   = (w_state != W_IDLE) &&
                      (sel_addr[ADDR_W-1:2] == aw_addr[ADDR_W-1:2]);

    assign wr_go = resetn && (|grant) && sel_wr && (w_state == W_IDLE);
    assign rd_go = resetn && (|grant) && !sel_wr &&
                   (r_state == R_IDLE) && !sel_pend && !hazard;

    assign addr_ok = (wr_go || rd_go) ? grant : '0;

    // Responses for ids with no outstanding read are dropped.
    always_comb begin
        r_ok = '0;
        for (int k = 0; k < NUM_MST; k++) begin
            r_ok[k] = rvalid && (rid == ID_W'(k)) && rd_pend[k];
        end
    end

    always_comb begin
        r_next  = r_state;
        arvalid = 1'b0;
        unique case (r_state)
            R_IDLE: if (rd_go) r_next = R_ADDR;
            R_ADDR: begin
                arvalid = 1'b1;
                if (arready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_next  = w_state;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        w_ok    = '0;
        unique case (w_state)
            W_IDLE: if (wr_go) w_next = W_SEND;
            W_SEND: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || awready) && (w_done || wready))
                    w_next = W_RESP;
            end
            W_RESP: begin
                if (bvalid) begin
                    w_next = W_IDLE;
                    for (int k = 0; k < NUM_MST; k++) begin
                        w_ok[k] = (wr_owner == ID_W'(k));
                    end
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
        end else begin
            r_state <= r_next;
            w_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_pend <= '0;
            ar_addr <= '0;
            ar_size <= '0;
            ar_id   <= '0;
        end else begin
            rd_pend <= (rd_pend & ~r_ok) | (rd_go ? grant : '0);
            if (rd_go) begin
                ar_addr <= sel_addr;
                ar_size <= sel_size;
                ar_id   <= sel_id;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_addr  <= '0;
            aw_size  <= '0;
            w_strb   <= '0;
            w_data   <= '0;
            wr_owner <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            if (wr_go) begin
                aw_addr  <= sel_addr;
                aw_size  <= sel_size;
                w_strb   <= sel_strb;
                w_data   <= sel_data;
                wr_owner <= sel_id;
            end
            if (w_state == W_IDLE) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (awvalid && awready) aw_done <= 1'b1;
                if (wvalid && wready)   w_done  <= 1'b1;
            end
        end
    end

    assign data_ok   = resetn ? (r_ok | w_ok) : '0;
    assign rdata     = axi_rdata;
    assign rready    = resetn;
    assign bready    = resetn;

    assign arid      = ar_id;
    assign araddr    = ar_addr;
    assign arlen     = 8'd0;
    assign arsize    = {1'b0, ar_size};
    assign arburst   = AXI_BURST_INCR;

    assign awid      = '0;
    assign awaddr    = aw_addr;
    assign awlen     = 8'd0;
    assign awsize    = {1'b0, aw_size};
    assign awburst   = AXI_BURST_INCR;
    assign axi_wdata = w_data;
    assign axi_wstrb = w_strb;
    assign wlast     = 1'b1;

    assign unused_ok = ^{rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge: 2-port instance plus a 4-port instance.
// Inputs change at posedge+1, outputs are sampled at posedge+2.
module tb_cpu_axi_bridge;

    logic clk, resetn;
    logic [1:0]  req, wr, addr_ok, data_ok;
    logic [3:0]  size;
    logic [63:0] addr, wdata;
    logic [7:0]  wstrb;
    logic [31:0] rdata, araddr, awaddr, axi_wdata, axi_rdata;
    logic [3:0]  arid, awid, rid, bid, axi_wstrb;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic arvalid, arready, rlast, rvalid, rready;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    logic [3:0]   req4, wr4, addr_ok4, data_ok4;
    logic [7:0]   size4;
    logic [127:0] addr4, wdata4;
    logic [15:0]  wstrb4;
    logic [31:0]  rdata4, araddr4, awaddr4, axi_wdata4;
    logic [3:0]   arid4, awid4, axi_wstrb4;
    logic [7:0]   arlen4, awlen4;
    logic [2:0]   arsize4, awsize4;
    logic [1:0]   arburst4, awburst4;
    logic arvalid4, rready4, awvalid4, wlast4, wvalid4, bready4;

    int checks = 0;
    int failures = 0;

    cpu_axi_bridge #(.NUM_MST(2)) dut (
        .clk(clk), .resetn(resetn),
        .req(req), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .axi_rdata(axi_rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    cpu_axi_bridge #(.NUM_MST(4)) dut4 (
        .clk(clk), .resetn(resetn),
        .req(req4), .wr(wr4), .size(size4), .addr(addr4),
        .wstrb(wstrb4), .wdata(wdata4),
        .addr_ok(addr_ok4), .data_ok(data_ok4), .rdata(rdata4),
        .arid(arid4), .araddr(araddr4), .arlen(arlen4), .arsize(arsize4),
        .arburst(arburst4), .arvalid(arvalid4), .arready(arready),
        .rid(rid), .axi_rdata(axi_rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready4),
        .awid(awid4), .awaddr(awaddr4), .awlen(awlen4), .awsize(awsize4),
        .awburst(awburst4), .awvalid(awvalid4), .awready(awready),
        .axi_wdata(axi_wdata4), .axi_wstrb(axi_wstrb4), .wlast(wlast4),
        .wvalid(wvalid4), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic w,
                            input logic [31:0] a, input logic [31:0] d);
        wr[p] = w;
        addr[p*32 +: 32] = a;
        size[p*2 +: 2] = 2'd2;
        wstrb[p*4 +: 4] = 4'hF;
        wdata[p*32 +: 32] = d;
    endtask

    task automatic test_reset();
        req = 2'b11;
        #1;
        checks++; if (addr_ok !== 2'b00) begin failures++; $display("FAIL rst_addr_ok got=%b exp=00", addr_ok); end
        checks++; if (data_ok !== 2'b00) begin failures++; $display("FAIL rst_data_ok got=%b exp=00", data_ok); end
        checks++; if ({arvalid, awvalid, wvalid} !== 3'b000) begin failures++; $display("FAIL rst_valids got=%b exp=000", {arvalid, awvalid, wvalid}); end
        checks++; if ({rready, bready} !== 2'b00) begin failures++; $display("FAIL rst_readys got=%b exp=00", {rready, bready}); end
        req = 2'b00;
        cyc();
        resetn = 1'b1;
        #1;
        checks++; if ({rready, bready} !== 2'b11) begin failures++; $display("FAIL run_readys got=%b exp=11", {rready, bready}); end
        checks++; if ({arlen, awlen} !== 16'h0) begin failures++; $display("FAIL lens got=%h exp=0000", {arlen, awlen}); end
        checks++; if ({arburst, awburst} !== 4'b0101) begin failures++; $display("FAIL bursts got=%b exp=0101", {arburst, awburst}); end
        checks++; if ({wlast, awid} !== 5'b10000) begin failures++; $display("FAIL wlast_awid got=%b exp=10000", {wlast, awid}); end
    endtask

    task automatic test_read();
        cyc();
        arready = 1'b1;
        req = 2'b10; set_port(1, 1'b0, 32'h1c000000, 32'h0);
        #1;
        checks++; if (addr_ok !== 2'b10) begin failures++; $display("FAIL rd_addr_ok got=%b exp=10", addr_ok); end
        cyc();
        req = 2'b00;
        #1;
        checks++; if ({arvalid, arid} !== 5'b1_0001) begin failures++; $display("FAIL rd_arvalid_id got=%b exp=10001", {arvalid, arid}); end
        checks++; if (araddr !== 32'h1c000000 || arsize !== 3'd2) begin failures++; $display("FAIL rd_araddr got=%h/%0d exp=1c000000/2", araddr, arsize); end
        cyc();
        checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL rd_ar_drop got=%b exp=0", arvalid); end
        cyc();
        checks++; if (data_ok !== 2'b00) begin failures++; $display("FAIL rd_early got=%b exp=00", data_ok); end
        cyc();
        rvalid = 1'b1; rid = 4'd1; axi_rdata = 32'hDEADBEEF;
        req = 2'b10; set_port(1, 1'b0, 32'h1c000010, 32'h0);
        #1;
        checks++; if (data_ok !== 2'b10 || rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%b/%h exp=10/deadbeef", data_ok, rdata); end
        checks++; if (addr_ok !== 2'b00) begin failures++; $display("FAIL rd_same_cycle got=%b exp=00", addr_ok); end
        cyc();
        rvalid = 1'b0;
        #1;
        checks++; if (addr_ok !== 2'b10) begin failures++; $display("FAIL rd_next_cycle got=%b exp=10", addr_ok); end
        cyc();
        req = 2'b00;
        cyc();
        rvalid = 1'b1; rid = 4'd1; axi_rdata = 32'h0;
        cyc();
        rvalid = 1'b0;
    endtask

    task automatic test_priority();
        cyc();
        req = 2'b11;
        set_port(0, 1'b0, 32'h200, 32'h0);
        set_port(1, 1'b0, 32'h300, 32'h0);
        #1;
        checks++; if (addr_ok !== 2'b01) begin failures++; $display("FAIL pri_first got=%b exp=01", addr_ok); end
        cyc();
        req = 2'b10;
        #1;
        checks++; if (addr_ok !== 2'b00 || arid !== 4'd0) begin failures++; $display("FAIL pri_busy got=%b/%0d exp=00/0", addr_ok, arid); end
        cyc();
        checks++; if (addr_ok !== 2'b10) begin failures++; $display("FAIL pri_second got=%b exp=10", addr_ok); end
        cyc();
        req = 2'b00;
        #1;
        checks++; if (arid !== 4'd1 || araddr !== 32'h300) begin failures++; $display("FAIL pri_arid got=%0d/%h exp=1/300", arid, araddr); end
        cyc();
        rvalid = 1'b1; rid = 4'd1; axi_rdata = 32'h11111111;
        #1;
        checks++; if (data_ok !== 2'b10 || rdata !== 32'h11111111) begin failures++; $display("FAIL ooo_p1 got=%b/%h exp=10/11111111", data_ok, rdata); end
        cyc();
        rid = 4'd0; axi_rdata = 32'h22222222;
        #1;
        checks++; if (data_ok !== 2'b01 || rdata !== 32'h22222222) begin failures++; $display("FAIL ooo_p0 got=%b/%h exp=01/22222222", data_ok, rdata); end
        cyc();
        rid = 4'd1;
        #1;
        checks++; if (data_ok !== 2'b00) begin failures++; $display("FAIL stray_rid got=%b exp=00", data_ok); end
        cyc();
        rvalid = 1'b0;
    endtask

    task automatic test_write();
        cyc();
        awready = 1'b0; wready = 1'b1;
        req = 2'b01; set_port(0, 1'b1, 32'h100, 32'h12345678);
        #1;
        checks++; if (addr_ok !== 2'b01) begin failures++; $display("FAIL wr_addr_ok got=%b exp=01", addr_ok); end
        cyc();
        req = 2'b00;
        #1;
        checks++; if ({awvalid, wvalid} !== 2'b11) begin failures++; $display("FAIL wr_valids got=%b exp=11", {awvalid, wvalid}); end
        checks++; if (awaddr !== 32'h100 || axi_wdata !== 32'h12345678 || axi_wstrb !== 4'hF) begin failures++; $display("FAIL wr_payload got=%h/%h/%h exp=100/12345678/f", awaddr, axi_wdata, axi_wstrb); end
        cyc();
        checks++; if ({awvalid, wvalid} !== 2'b10) begin failures++; $display("FAIL wr_wdrop got=%b exp=10", {awvalid, wvalid}); end
        cyc();
        awready = 1'b1;
        cyc();
        awready = 1'b0;
        #1;
        checks++; if ({awvalid, wvalid, data_ok} !== 4'b0000) begin failures++; $display("FAIL wr_resp_wait got=%b exp=0000", {awvalid, wvalid, data_ok}); end
        cyc();
        bvalid = 1'b1;
        #1;
        checks++; if (data_ok !== 2'b01) begin failures++; $display("FAIL wr_bvalid got=%b exp=01", data_ok); end
        cyc();
        bvalid = 1'b0;
        #1;
        checks++; if (data_ok !== 2'b00) begin failures++; $display("FAIL wr_done got=%b exp=00", data_ok); end
    endtask

    task automatic test_hazard();
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        cyc();
        req = 2'b01; set_port(0, 1'b1, 32'h100, 32'hA5A5A5A5);
        cyc();
        set_port(0, 1'b0, 32'h102, 32'h0);
        #1;
        checks++; if (addr_ok !== 2'b00) begin failures++; $display("FAIL haz_send got=%b exp=00", addr_ok); end
        cyc();
        checks++; if ({addr_ok, awvalid, wvalid} !== 4'b0000) begin failures++; $display("FAIL haz_resp got=%b exp=0000", {addr_ok, awvalid, wvalid}); end
        cyc();
        bvalid = 1'b1;
        #1;
        checks++; if ({data_ok, addr_ok} !== 4'b0100) begin failures++; $display("FAIL haz_bvalid got=%b exp=0100", {data_ok, addr_ok}); end
        cyc();
        bvalid = 1'b0;
        #1;
        checks++; if (addr_ok !== 2'b01) begin failures++; $display("FAIL haz_clear got=%b exp=01", addr_ok); end
        cyc();
        req = 2'b00;
        #1;
        checks++; if (arvalid !== 1'b1 || araddr !== 32'h102) begin failures++; $display("FAIL haz_ar got=%b/%h exp=1/102", arvalid, araddr); end
        cyc();
        rvalid = 1'b1; rid = 4'd0;
        cyc();
        rvalid = 1'b0;
        req = 2'b01; set_port(0, 1'b1, 32'h100, 32'h5A5A5A5A);
        cyc();
        set_port(0, 1'b0, 32'h104, 32'h0);
        #1;
        checks++; if (addr_ok !== 2'b01) begin failures++; $display("FAIL nohaz_104 got=%b exp=01", addr_ok); end
        cyc();
        req = 2'b00;
        cyc();
        rvalid = 1'b1; rid = 4'd0;
        cyc();
        rvalid = 1'b0; bvalid = 1'b1;
        req = 2'b01; set_port(0, 1'b1, 32'h108, 32'h0BADF00D);
        #1;
        checks++; if ({data_ok, addr_ok} !== 4'b0100) begin failures++; $display("FAIL wr_b_same got=%b exp=0100", {data_ok, addr_ok}); end
        cyc();
        bvalid = 1'b0;
        #1;
        checks++; if (addr_ok !== 2'b01) begin failures++; $display("FAIL wr_b_next got=%b exp=01", addr_ok); end
        cyc();
        req = 2'b00;
        #1;
        checks++; if (awvalid !== 1'b1 || awaddr !== 32'h108) begin failures++; $display("FAIL wr2_aw got=%b/%h exp=1/108", awvalid, awaddr); end
        cyc();
        bvalid = 1'b1;
        cyc();
        bvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        cyc();
        req = 2'b01; set_port(0, 1'b1, 32'h400, 32'h0);
        cyc();
        req = 2'b10; set_port(1, 1'b0, 32'h500, 32'h0);
        #1;
        checks++; if (addr_ok !== 2'b10) begin failures++; $display("FAIL mid_rd_acc got=%b exp=10", addr_ok); end
        cyc();
        req = 2'b00;
        #1;
        checks++; if ({arvalid, awvalid, wvalid} !== 3'b111) begin failures++; $display("FAIL mid_busy got=%b exp=111", {arvalid, awvalid, wvalid}); end
        #1;
        resetn = 1'b0;
        #1;
        checks++; if ({arvalid, awvalid, wvalid} !== 3'b000) begin failures++; $display("FAIL mid_async got=%b exp=000", {arvalid, awvalid, wvalid}); end
        cyc();
        resetn = 1'b1;
        arready = 1'b1;
        cyc();
        req = 2'b10; set_port(1, 1'b0, 32'h600, 32'h0);
        #1;
        checks++; if (addr_ok !== 2'b10) begin failures++; $display("FAIL post_rst_acc got=%b exp=10", addr_ok); end
        cyc();
        req = 2'b00;
        #1;
        checks++; if (arvalid !== 1'b1 || araddr !== 32'h600 || arid !== 4'd1) begin failures++; $display("FAIL post_rst_ar got=%b/%h/%0d exp=1/600/1", arvalid, araddr, arid); end
        cyc();
        rvalid = 1'b1; rid = 4'd1; axi_rdata = 32'hCAFEF00D;
        #1;
        checks++; if (data_ok !== 2'b10 || rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL post_rst_r got=%b/%h exp=10/cafef00d", data_ok, rdata); end
        cyc();
        rvalid = 1'b0;
    endtask

    task automatic test_num4();
        arready = 1'b1;
        cyc();
        req4 = 4'b1100;
        addr4[2*32 +: 32] = 32'h2000;
        addr4[3*32 +: 32] = 32'h3000;
        #1;
        checks++; if (addr_ok4 !== 4'b0100) begin failures++; $display("FAIL n4_first got=%b exp=0100", addr_ok4); end
        cyc();
        req4 = 4'b1000;
        #1;
        checks++; if (addr_ok4 !== 4'b0000 || arid4 !== 4'd2) begin failures++; $display("FAIL n4_busy got=%b/%0d exp=0000/2", addr_ok4, arid4); end
        cyc();
        checks++; if (addr_ok4 !== 4'b1000) begin failures++; $display("FAIL n4_second got=%b exp=1000", addr_ok4); end
        cyc();
        req4 = 4'b0000;
        #1;
        checks++; if (arid4 !== 4'd3 || araddr4 !== 32'h3000) begin failures++; $display("FAIL n4_arid got=%0d/%h exp=3/3000", arid4, araddr4); end
        cyc();
        rvalid = 1'b1; rid = 4'd3;
        #1;
        checks++; if (data_ok4 !== 4'b1000 || data_ok !== 2'b00) begin failures++; $display("FAIL n4_route got=%b/%b exp=1000/00", data_ok4, data_ok); end
        cyc();
        rvalid = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        req = '0; wr = '0; size = '0; addr = '0; wstrb = '0; wdata = '0;
        req4 = '0; wr4 = '0; size4 = '0; addr4 = '0; wstrb4 = '0; wdata4 = '0;
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rvalid = 1'b0; rid = '0; axi_rdata = '0; rresp = '0; rlast = 1'b1;
        bvalid = 1'b0; bid = '0; bresp = '0;
        test_reset();
        test_read();
        test_priority();
        test_write();
        test_hazard();
        test_reset_mid();
        test_num4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
